// File: rtl/rv_mem_pkg.sv
// Shared types for the RV32 memory-access stage (rv_mem).
package rv_mem_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } t_mem_size;

    typedef enum logic [1:0] {
        SEL_WB_ALU = 2'd0,
        SEL_WB_MEM = 2'd1,
        SEL_WB_PC4 = 2'd2
    } t_sel_wb;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } t_mem_state;

    typedef struct packed {
        logic      rd_en;
        logic      wr_en;
        t_mem_size size;
        logic      is_unsigned;
        t_sel_wb   sel_wb;
        logic      reg_write_en;
        logic [4:0] rd;
    } t_mem_ctrl;

    // Half accesses only look at addr[1]; word accesses are always full-lane.
    function automatic logic [3:0] store_be(input t_mem_size size, input logic [1:0] off);
        unique case (size)
            MEM_BYTE: store_be = 4'b0001 << off;
            MEM_HALF: store_be = off[1] ? 4'b1100 : 4'b0011;
            default:  store_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/rv_mem_load_align.sv
// Load data alignment and sign/zero extension for rv_mem.
module rv_load_align
    import rv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        mem_unsigned,
    output logic [31:0] load_data
);

    t_mem_size   sz;
    logic [1:0]  eff_off;
    logic [31:0] shifted;

    always_comb begin
        sz = t_mem_size'(size);
        unique case (sz)
            MEM_BYTE: eff_off = off;
            MEM_HALF: eff_off = {off[1], 1'b0};
            default:  eff_off = 2'b00;
        endcase
        shifted = rdata >> {eff_off, 3'b000};
        unique case (sz)
            MEM_BYTE: load_data = {{24{~mem_unsigned & shifted[7]}}, shifted[7:0]};
            MEM_HALF: load_data = {{16{~mem_unsigned & shifted[15]}}, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

endmodule

// File: rtl/rv_mem.sv
// RV32 memory-access stage: dmem request/response handshake, load alignment, Q104H writeback.
// Optional misaligned-access trap enabled by RV_MEM_MISALIGN_TRAP_EN.
module rv_mem
    import rv_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_rd_en_Q103H,
    input  logic            mem_wr_en_Q103H,
    input  logic [1:0]      mem_size_Q103H,
    input  logic            mem_unsigned_Q103H,
    input  logic [1:0]      sel_wb_Q103H,
    input  logic            reg_write_en_Q103H,
    input  logic [4:0]      rd_Q103H,
    input  logic [XLEN-1:0] alu_out_Q103H,
    input  logic [XLEN-1:0] dmem_wr_data_Q103H,
    input  logic [XLEN-1:0] pc_plus4_Q103H,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [3:0]      dmem_req_be,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_rdata,
    output logic            stall_Q103H,
    output logic [XLEN-1:0] wb_data_Q103H,
    output logic [XLEN-1:0] wb_data_Q104H,
    output logic [4:0]      rd_Q104H,
    output logic            reg_write_en_Q104H
`ifdef RV_MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign_Q104H,
    output logic [XLEN-1:0] misalign_addr_Q104H
`endif
);

    t_mem_ctrl   ctrl;
    t_mem_state  state, state_next;
    logic        access, misalign, issue, load_hs;
    logic [1:0]  off, cap_off;
    t_mem_size   cap_size;
    logic        cap_unsigned;
    logic [31:0] load_data;

    always_comb begin
        ctrl = '{
            rd_en:        mem_rd_en_Q103H,
            wr_en:        mem_wr_en_Q103H,
            size:         t_mem_size'(mem_size_Q103H),
            is_unsigned:  mem_unsigned_Q103H,
            sel_wb:       t_sel_wb'(sel_wb_Q103H),
            reg_write_en: reg_write_en_Q103H,
            rd:           rd_Q103H
        };
        off    = alu_out_Q103H[1:0];
        access = ctrl.rd_en | ctrl.wr_en;
    end

`ifdef RV_MEM_MISALIGN_TRAP_EN
    assign misalign = access & (((ctrl.size == MEM_HALF) & off[0]) |
                                ((ctrl.size == MEM_WORD) & (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif
    assign issue = access & ~misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (issue) state_next = !dmem_req_ready ? REQ : (ctrl.rd_en ? RSP : IDLE);
            REQ:  if (dmem_req_ready) state_next = ctrl.rd_en ? RSP : IDLE;
            RSP:  if (dmem_rsp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A store retires in its handshake cycle; a load holds the pipe until its response.
    always_comb begin
        dmem_req_valid = 1'b0;
        stall_Q103H    = 1'b0;
        unique case (state)
            IDLE: begin
                dmem_req_valid = issue;
                stall_Q103H    = issue & ~(ctrl.wr_en & dmem_req_ready);
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                stall_Q103H    = ~(ctrl.wr_en & dmem_req_ready);
            end
            RSP:     stall_Q103H = ~dmem_rsp_valid;
            default: ;
        endcase
    end

    always_comb begin
        dmem_req_we   = ctrl.wr_en;
        dmem_req_addr = alu_out_Q103H;
        dmem_req_be   = ctrl.wr_en ? store_be(ctrl.size, off) : 4'b0000;
        unique case (ctrl.size)
            MEM_BYTE: dmem_req_wdata = {4{dmem_wr_data_Q103H[7:0]}};
            MEM_HALF: dmem_req_wdata = {2{dmem_wr_data_Q103H[15:0]}};
            default:  dmem_req_wdata = dmem_wr_data_Q103H;
        endcase
        unique case (ctrl.sel_wb)
            SEL_WB_ALU: wb_data_Q103H = alu_out_Q103H;
            SEL_WB_PC4: wb_data_Q103H = pc_plus4_Q103H;
            default:    wb_data_Q103H = '0;
        endcase
    end

    assign load_hs = dmem_req_valid & dmem_req_ready & ctrl.rd_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_off      <= '0;
            cap_size     <= MEM_BYTE;
            cap_unsigned <= 1'b0;
        end else if (load_hs) begin
            cap_off      <= off;
            cap_size     <= ctrl.size;
            cap_unsigned <= ctrl.is_unsigned;
        end
    end

    rv_load_align u_align (
        .rdata        (dmem_rsp_rdata),
        .off          (cap_off),
        .size         (cap_size),
        .mem_unsigned (cap_unsigned),
        .load_data    (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data_Q104H      <= '0;
            rd_Q104H           <= '0;
            reg_write_en_Q104H <= 1'b0;
        end else if (stall_Q103H) begin
            reg_write_en_Q104H <= 1'b0;
        end else begin
            rd_Q104H           <= ctrl.rd;
            reg_write_en_Q104H <= ctrl.reg_write_en & ~misalign;
            wb_data_Q104H      <= (ctrl.sel_wb == SEL_WB_MEM) ? load_data : wb_data_Q103H;
        end
    end

`ifdef RV_MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_Q104H      <= 1'b0;
            misalign_addr_Q104H <= '0;
        end else begin
            misalign_Q104H <= misalign & ~stall_Q103H;
            if (misalign & ~stall_Q103H) misalign_addr_Q104H <= alu_out_Q103H;
        end
    end
`endif

endmodule

// File: tb/tb_rv_mem.sv
// Directed self-checking bench for rv_mem (optionally with RV_MEM_MISALIGN_TRAP_EN).
module tb_rv_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd_en_Q103H, mem_wr_en_Q103H, mem_unsigned_Q103H, reg_write_en_Q103H;
    logic [1:0]  mem_size_Q103H, sel_wb_Q103H;
    logic [4:0]  rd_Q103H;
    logic [31:0] alu_out_Q103H, dmem_wr_data_Q103H, pc_plus4_Q103H;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        stall_Q103H;
    logic [31:0] wb_data_Q103H, wb_data_Q104H;
    logic [4:0]  rd_Q104H;
    logic        reg_write_en_Q104H;
`ifdef RV_MEM_MISALIGN_TRAP_EN
    logic        misalign_Q104H;
    logic [31:0] misalign_addr_Q104H;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_mem dut (
        .clk(clk), .rst(rst),
        .mem_rd_en_Q103H(mem_rd_en_Q103H), .mem_wr_en_Q103H(mem_wr_en_Q103H),
        .mem_size_Q103H(mem_size_Q103H), .mem_unsigned_Q103H(mem_unsigned_Q103H),
        .sel_wb_Q103H(sel_wb_Q103H), .reg_write_en_Q103H(reg_write_en_Q103H),
        .rd_Q103H(rd_Q103H), .alu_out_Q103H(alu_out_Q103H),
        .dmem_wr_data_Q103H(dmem_wr_data_Q103H), .pc_plus4_Q103H(pc_plus4_Q103H),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
        .stall_Q103H(stall_Q103H), .wb_data_Q103H(wb_data_Q103H),
        .wb_data_Q104H(wb_data_Q104H), .rd_Q104H(rd_Q104H),
        .reg_write_en_Q104H(reg_write_en_Q104H)
`ifdef RV_MEM_MISALIGN_TRAP_EN
        , .misalign_Q104H(misalign_Q104H), .misalign_addr_Q104H(misalign_addr_Q104H)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        mem_rd_en_Q103H = 0; mem_wr_en_Q103H = 0; mem_size_Q103H = 2'd0;
        mem_unsigned_Q103H = 0; sel_wb_Q103H = 2'd0; reg_write_en_Q103H = 0;
        rd_Q103H = '0; alu_out_Q103H = '0; dmem_wr_data_Q103H = '0;
        pc_plus4_Q103H = '0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = '0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [4:0] rd);
        idle_in();
        mem_rd_en_Q103H = 1; mem_size_Q103H = size; mem_unsigned_Q103H = uns;
        sel_wb_Q103H = 2'd1; reg_write_en_Q103H = 1; rd_Q103H = rd; alu_out_Q103H = addr;
    endtask

    task automatic set_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
        idle_in();
        mem_wr_en_Q103H = 1; mem_size_Q103H = size; alu_out_Q103H = addr; dmem_wr_data_Q103H = data;
    endtask

    initial begin
        idle_in();
        rst = 1;
        tick(); tick();
        chk("rst_valid", {31'b0, dmem_req_valid}, 0);
        chk("rst_stall", {31'b0, stall_Q103H}, 0);
        chk("rst_wb104", wb_data_Q104H, 0);
        chk("rst_rd104", {27'b0, rd_Q104H}, 0);
        chk("rst_we104", {31'b0, reg_write_en_Q104H}, 0);
        rst = 0;
        tick();

        // SW 0x100, ready high
        set_store(32'h100, 2'd2, 32'hDEADBEEF); dmem_req_ready = 1; #1;
        chk("sw_valid", {31'b0, dmem_req_valid}, 1);
        chk("sw_we",    {31'b0, dmem_req_we}, 1);
        chk("sw_be",    {28'b0, dmem_req_be}, 32'hF);
        chk("sw_addr",  dmem_req_addr, 32'h100);
        chk("sw_wdata", dmem_req_wdata, 32'hDEADBEEF);
        chk("sw_stall", {31'b0, stall_Q103H}, 0);
        tick(); idle_in(); #1;
        chk("sw_idle_valid", {31'b0, dmem_req_valid}, 0);

        // SB 0x103, ready low 3 cycles
        set_store(32'h103, 2'd0, 32'h000000A5); #1;
        for (int i = 0; i < 3; i++) begin
            chk("sb_wait_valid", {31'b0, dmem_req_valid}, 1);
            chk("sb_wait_be",    {28'b0, dmem_req_be}, 32'h8);
            chk("sb_wait_wdata", dmem_req_wdata, 32'hA5A5A5A5);
            chk("sb_wait_addr",  dmem_req_addr, 32'h103);
            chk("sb_wait_stall", {31'b0, stall_Q103H}, 1);
            tick(); #1;
        end
        dmem_req_ready = 1; #1;
        chk("sb_hs_valid", {31'b0, dmem_req_valid}, 1);
        chk("sb_hs_be",    {28'b0, dmem_req_be}, 32'h8);
        chk("sb_hs_stall", {31'b0, stall_Q103H}, 0);
        tick(); idle_in(); #1;
        chk("sb_done_valid", {31'b0, dmem_req_valid}, 0);

        // Lane checks: SH 0x102, SB 0x101, LW has no byte enables
        set_store(32'h102, 2'd1, 32'h1234BEEF); dmem_req_ready = 1; #1;
        chk("sh_be",    {28'b0, dmem_req_be}, 32'hC);
        chk("sh_wdata", dmem_req_wdata, 32'hBEEFBEEF);
        tick();
        set_store(32'h101, 2'd0, 32'h00000077); dmem_req_ready = 1; #1;
        chk("sb1_be",    {28'b0, dmem_req_be}, 32'h2);
        chk("sb1_wdata", dmem_req_wdata, 32'h77777777);
        tick();

        // Forwarding mux and JAL-type writeback
        idle_in(); sel_wb_Q103H = 2'd0; alu_out_Q103H = 32'h1234; #1;
        chk("fwd_alu", wb_data_Q103H, 32'h1234);
        sel_wb_Q103H = 2'd1; #1;
        chk("fwd_mem_zero", wb_data_Q103H, 0);
        idle_in(); sel_wb_Q103H = 2'd2; pc_plus4_Q103H = 32'h2004;
        reg_write_en_Q103H = 1; rd_Q103H = 5'd1; #1;
        chk("jal_wb103", wb_data_Q103H, 32'h2004);
        chk("jal_valid", {31'b0, dmem_req_valid}, 0);
        tick();
        chk("jal_wb104", wb_data_Q104H, 32'h2004);
        chk("jal_we104", {31'b0, reg_write_en_Q104H}, 1);
        chk("jal_rd104", {27'b0, rd_Q104H}, 1);

        // LB 0x101, 2-cycle wait then rdata 0x00008000
        set_load(32'h101, 2'd0, 0, 5'd5); dmem_req_ready = 1; #1;
        chk("lb_valid", {31'b0, dmem_req_valid}, 1);
        chk("lb_we",    {31'b0, dmem_req_we}, 0);
        chk("lb_be",    {28'b0, dmem_req_be}, 0);
        chk("lb_stall", {31'b0, stall_Q103H}, 1);
        tick(); dmem_req_ready = 0;
        chk("lb_bubble_we",   {31'b0, reg_write_en_Q104H}, 0);
        chk("lb_bubble_hold", wb_data_Q104H, 32'h2004);
        chk("lb_wait_valid",  {31'b0, dmem_req_valid}, 0);
        chk("lb_wait_stall",  {31'b0, stall_Q103H}, 1);
        tick();
        chk("lb_wait2_stall", {31'b0, stall_Q103H}, 1);
        dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h00008000; #1;
        chk("lb_rsp_stall", {31'b0, stall_Q103H}, 0);
        tick(); idle_in();
        chk("lb_wb104", wb_data_Q104H, 32'hFFFFFF80);
        chk("lb_we104", {31'b0, reg_write_en_Q104H}, 1);
        chk("lb_rd104", {27'b0, rd_Q104H}, 5);
        tick();
        chk("lb_we_pulse", {31'b0, reg_write_en_Q104H}, 0);

        // LHU / LH at 0x102, rdata 0xF00D1234
        for (int u = 1; u >= 0; u--) begin
            set_load(32'h102, 2'd1, u[0], 5'd7); dmem_req_ready = 1;
            tick(); dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hF00D1234; #1;
            chk("lh_rsp_stall", {31'b0, stall_Q103H}, 0);
            tick(); idle_in();
            chk(u ? "lhu_wb104" : "lh_wb104", wb_data_Q104H, u ? 32'h0000F00D : 32'hFFFFF00D);
        end

        // Reset while in RSP, then a stray response
        set_load(32'h104, 2'd2, 0, 5'd9); dmem_req_ready = 1; #1;
        chk("rstmid_valid", {31'b0, dmem_req_valid}, 1);
        tick(); dmem_req_ready = 0;
        chk("rstmid_stall_rsp", {31'b0, stall_Q103H}, 1);
        idle_in(); rst = 1; #1;
        chk("rstmid_valid_drop", {31'b0, dmem_req_valid}, 0);
        chk("rstmid_stall_drop", {31'b0, stall_Q103H}, 0);
        dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hCAFEF00D;
        tick();
        chk("rstmid_we104", {31'b0, reg_write_en_Q104H}, 0);
        chk("rstmid_wb104", wb_data_Q104H, 0);
        rst = 0; #1;
        chk("stray_stall", {31'b0, stall_Q103H}, 0);
        tick();
        chk("stray_we104", {31'b0, reg_write_en_Q104H}, 0);
        chk("stray_wb104", wb_data_Q104H, 0);

`ifdef RV_MEM_MISALIGN_TRAP_EN
        set_load(32'h102, 2'd2, 0, 5'd3); dmem_req_ready = 1; #1;
        chk("mis_valid", {31'b0, dmem_req_valid}, 0);
        chk("mis_stall", {31'b0, stall_Q103H}, 0);
        tick(); idle_in();
        chk("mis_pulse", {31'b0, misalign_Q104H}, 1);
        chk("mis_addr",  misalign_addr_Q104H, 32'h102);
        chk("mis_we104", {31'b0, reg_write_en_Q104H}, 0);
        tick();
        chk("mis_pulse_end", {31'b0, misalign_Q104H}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mem.md
Name: rv_mem

Overview:
- Memory-access stage of the pipeline: consumer of the execute stage's Q103H results (ALU address, store data, PC+4).
- Issues load/store requests to data memory over a valid/ready request channel and a valid response channel.
- Aligns and extends load data, stalls the pipeline while an access is outstanding, and registers writeback results into Q104H.
- Supplies the forwarding data wb_data_Q103H and wb_data_Q104H.

Parameters:
- none; widths fixed at RV32 (XLEN 32, 5-bit register index).

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- mem_rd_en_Q103H  in  1  load in Q103H
- mem_wr_en_Q103H  in  1  store in Q103H (never together with rd_en)
- mem_size_Q103H  in  2  t_mem_size: byte / half / word
- mem_unsigned_Q103H  in  1  zero-extend load (LBU/LHU)
- sel_wb_Q103H  in  2  t_sel_wb: ALU / MEM / PC4
- reg_write_en_Q103H  in  1  instruction writes rd
- rd_Q103H  in  5  destination register
- alu_out_Q103H  in  32  ALU result / effective address
- dmem_wr_data_Q103H  in  32  store data (rs2)
- pc_plus4_Q103H  in  32  link value
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = write
- dmem_req_addr  out  32  byte address (memory uses [31:2])
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_be  out  4  byte enables (0 for loads)
- dmem_rsp_valid  in  1  read data valid
- dmem_rsp_rdata  in  32  read word
- stall_Q103H  out  1  hold Q103H and all earlier stages
- wb_data_Q103H  out  32  forwarding value: ALU or PC+4; 0 when sel_wb = MEM
- wb_data_Q104H  out  32  registered writeback data
- rd_Q104H  out  5  registered rd
- reg_write_en_Q104H  out  1  registered write enable

Behaviour:
- FSM t_mem_state has three states: IDLE, REQ, RSP. Reset sets state IDLE and all Q104H outputs to 0.
- access = mem_rd_en_Q103H | mem_wr_en_Q103H.
- dmem_req_valid = (IDLE & access) | REQ. This is combinational, so a request can issue in the first cycle.
- While valid is high, addr, we, wdata and be stay stable until the handshake. They are derived from Q103H, which is held by the stall.
- IDLE transitions:
  - access and no ready -> REQ.
  - load with ready -> RSP.
  - store with ready -> IDLE.
- REQ transitions: on ready, a load goes to RSP and a store goes to IDLE.
- RSP transition: on rsp_valid -> IDLE.
- rsp_valid is ignored outside RSP. A response that arrives after a reset is dropped.
- Store latency is 1 cycle minimum. stall_Q103H is high only in cycles with no handshake; a store is committed in its handshake cycle.
- Load latency is at least 2 cycles. stall is high from request until rsp_valid, and low in the rsp_valid cycle. The load result is captured into Q104H on that edge.
- Q104H update rule:
  - When stall = 0, Q104H captures rd_Q103H, reg_write_en_Q103H, and the data selected by sel_wb (ALU, PC4, or aligned load).
  - When stall = 1, reg_write_en_Q104H is forced to 0 (bubble). rd_Q104H and wb_data_Q104H hold.
- Byte-lane rules, with off = addr[1:0]:
  - Byte store: be = 0001 << off; wdata = {4{wr_data[7:0]}}.
  - Half store: be = 0011 << (addr[1]*2); wdata = {2{wr_data[15:0]}}.
  - Word store: be = 1111.
- Load rules:
  - Shift rdata right by off*8.
  - Byte / half loads: sign-extend from bit 7/15, or zero-extend when mem_unsigned = 1.
  - Word loads: passed through.
  - off and size are captured at the request handshake, so alignment does not depend on Q103H in RSP.
- Reset mid-access: the FSM returns to IDLE asynchronously, request valid drops, and the outstanding response is discarded.

Optional Feature:
- Macro: RV_MEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, issues no request and no stall.
  - reg_write_en_Q104H is forced to 0.
  - Extra outputs misalign_Q104H (1-cycle pulse) and misalign_addr_Q104H [31:0] are registered; both reset to 0.
- Undefined: no extra ports. Offending low address bits are ignored: half uses addr[1] only, word is treated as aligned.

Decomposition:
- pkg holds:
  - t_mem_size enum: MEM_BYTE = 0, MEM_HALF = 1, MEM_WORD = 2.
  - t_sel_wb enum: SEL_WB_ALU, SEL_WB_MEM, SEL_WB_PC4.
  - t_mem_state enum: IDLE, REQ, RSP.
  - t_mem_ctrl struct bundling the Q103H control inputs.
- Sub-module rv_load_align (combinational): rdata, off, size, unsigned -> 32-bit extended load value.

Test Plan:
- SW, addr 0x100, data 0xDEADBEEF, ready high -> valid 1 cycle; be = 1111; we = 1; stall 0; next IDLE.
- SB, addr 0x103, data 0x000000A5, ready low for 3 cycles -> valid held 4 cycles with constant addr/be = 1000/wdata = 0xA5A5A5A5; stall high 3 cycles.
- LB, addr 0x101, rdata 0x00008000 after 2-cycle wait -> stall high until rsp; wb_data_Q104H = 0xFFFFFF80; reg_write_en_Q104H = 1 for 1 cycle, bubbles during stall.
- LHU, addr 0x102, rdata 0xF00D1234 -> wb_data_Q104H = 0x0000F00D; LH at the same address -> 0xFFFFF00D.
- JAL-type, sel_wb = PC4, pc_plus4 = 0x2004, no access -> wb_data_Q103H = 0x2004, no request; next cycle wb_data_Q104H = 0x2004.
- rst asserted in RSP, then a stray rsp_valid -> state IDLE, outputs 0, no Q104H write. With the macro defined, LW at 0x102 -> no request, misalign_Q104H pulse, misalign_addr_Q104H = 0x102.
